// File: rtl/mul3_pkg.sv
// Shared definitions for the multiple-of-3 serial stream: FSM states,
// the mod-3 remainder step and the pad value that makes a frame divisible by 3.
package mul3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAD   = 2'd2
  } state_e;

  localparam int PAD_BITS = 2;

  // Appending bit b to a value with remainder r gives remainder (2r+b) mod 3.
  function automatic logic [1:0] rem_step(input logic [1:0] r, input logic b);
    logic [1:0] n;
    case ({r, b})
      3'b000:  n = 2'd0;
      3'b001:  n = 2'd1;
      3'b010:  n = 2'd2;
      3'b011:  n = 2'd0;
      3'b100:  n = 2'd1;
      3'b101:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] pad_value(input logic [1:0] r);
    logic [1:0] p;
    case (r)
      2'd1:    p = 2'd2;
      2'd2:    p = 2'd1;
      default: p = 2'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/mul3_rem_tracker.sv
// Running mod-3 remainder of a serial MSB-first stream, plus the golden
// divisibility flag for the bit currently on the wire.
module mul3_rem_tracker
  import mul3_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_valid_i,
  input  logic       bit_i,
  input  logic       clr_i,
  output logic [1:0] rem_o,
  output logic       exp_y_o
);

  logic [1:0] rem_q;
  logic [1:0] rem_d;

  always_comb begin
    rem_d   = rem_step(rem_q, bit_i);
    exp_y_o = bit_valid_i && (rem_d == 2'd0);
  end

  // clr wins over a step so a back-to-back frame starts from zero.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      rem_q <= 2'd0;
    end else if (bit_valid_i) begin
      rem_q <= rem_d;
    end
  end

  assign rem_o = rem_q;

endmodule

// File: rtl/mul_3_stream_tx.sv
// Serial MSB-first transmitter for the multiple-of-3 stream with golden exp_y.
// Define MUL3_PAD_EN to append 2 pad bits making every frame divisible by 3.
module mul_3_stream_tx
  import mul3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             sof,
  output logic             eof,
  output logic [1:0]       rem,
  output logic             exp_y,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             sof_q;
  logic             cur_bit;
  logic             accept;
`ifdef MUL3_PAD_EN
  logic [1:0]       pad_q;
`endif

  always_comb begin
    cur_bit = shreg_q[WIDTH-1];
`ifdef MUL3_PAD_EN
    if (state_q == ST_PAD) begin
      cur_bit = pad_q[cnt_q[0]];
    end
    eof = (state_q == ST_PAD) && (cnt_q == '0);
`else
    eof = (state_q == ST_SHIFT) && (cnt_q == '0);
`endif
    busy     = (state_q != ST_IDLE);
    x_valid  = busy;
    x        = busy && cur_bit;
    sof      = sof_q;
    in_ready = !reset && ((state_q == ST_IDLE) || eof);
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      sof_q   <= 1'b0;
`ifdef MUL3_PAD_EN
      pad_q   <= 2'd0;
`endif
    end else begin
      sof_q <= accept;
      if (accept) begin
        state_q <= ST_SHIFT;
        shreg_q <= in_data;
        cnt_q   <= LAST_IDX;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            shreg_q <= shreg_q << 1;
            if (cnt_q == '0) begin
`ifdef MUL3_PAD_EN
              // Pad is chosen from the remainder after the last data bit.
              state_q <= ST_PAD;
              cnt_q   <= CW'(PAD_BITS - 1);
              pad_q   <= pad_value(rem_step(rem, cur_bit));
`else
              state_q <= ST_IDLE;
`endif
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          ST_PAD: begin
            if (cnt_q == '0) begin
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  mul3_rem_tracker u_rem (
    .clk        (clk),
    .reset      (reset),
    .bit_valid_i(x_valid),
    .bit_i      (x),
    .clr_i      (accept),
    .rem_o      (rem),
    .exp_y_o    (exp_y)
  );

endmodule
